// File: rtl/serial_alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_pkg
// Description : Shared definitions for the bit-serial ALU controller:
//               operation codes, FSM state type and encoding, and a
//               helper that classifies an operation code as legal.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package serial_alu_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_ADD  = 3'b000;
  localparam mode_t MODE_AND  = 3'b001;
  localparam mode_t MODE_OR   = 3'b010;
  localparam mode_t MODE_XOR  = 3'b011;
  localparam mode_t MODE_XNOR = 3'b100;

  // FSM state type, encoded as plain two-bit constants.
  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Codes above XNOR have no slice operation behind them.
  function automatic logic mode_is_legal(input mode_t m);
    return (m <= MODE_XNOR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_alu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_ctrl_if
// Description : Host-side request/response bus of the serial ALU controller.
// Ports       : start, mode, a_in, b_in      (host -> controller)
//               result, carry, busy, done, err (controller -> host)
//               modport master : host side
//               modport slave  : controller side
// Revision    : 1.0  initial release
// ============================================================================
interface serial_alu_ctrl_if
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             start;
  mode_t            mode;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, mode, a_in, b_in,
    input  result, carry, busy, done, err
  );

  modport slave (
    input  start, mode, a_in, b_in,
    output result, carry, busy, done, err
  );

endinterface
`default_nettype wire

// File: rtl/serial_alu_ctrl_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : serial_shift_reg
// Description : WIDTH-bit right-shift register with parallel load, serial
//               input at the MSB and serial output from the LSB.
//               Load has priority over shift.
// Ports       : clk, rst            clock, synchronous active-high reset
//               load, load_data     parallel load strobe and data
//               shift, serial_in    shift-right strobe and MSB fill bit
//               q, serial_out       parallel contents and current LSB
// Revision    : 1.0  initial release
// ============================================================================
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_data;
    end else if (shift) begin
      r_q <= {serial_in, r_q[WIDTH-1:1]};
    end
  end

  assign q          = r_q;
  assign serial_out = r_q[0];

endmodule
`default_nettype wire

// File: rtl/serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_ctrl
// Description : Bit-serial ALU sequencer. Feeds operand bits LSB first to an
//               external 1-bit ALU slice, one bit per cycle, collects the
//               slice result bits into a word and reports completion.
// Ports       : clk, rst        clock, synchronous active-high reset
//               bus (slave)     start/mode/a_in/b_in request,
//                               result/carry/busy/done/err response
//               mode_bit        latched operation code to the slice
//               a_bit, b_bit    current operand bits to the slice
//               c_bit           carry-in to the slice
//               x, c_out        slice result bit and carry-out
// Revision    : 1.0  initial release
// ============================================================================
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_alu_ctrl_if.slave    bus,
  output logic [2:0]          mode_bit,
  output logic                a_bit,
  output logic                b_bit,
  output logic                c_bit,
  input  logic                x,
  input  logic                c_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;      // running carry between bit positions
  mode_t            r_mode;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_err;

  logic             w_run;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] w_a_q;
  logic [WIDTH-1:0] w_b_q;
  logic [WIDTH-1:0] w_res_q;
  logic             w_a_lsb;
  logic             w_b_lsb;
  logic             w_res_lsb;

  assign w_run  = (r_state == RUN);
  assign w_load = (r_state == IDLE) && bus.start && mode_is_legal(bus.mode);
  assign w_last = w_run && (r_cnt == c_last_cnt);

  // Operands shift out LSB first; zeros fill from the top.
  serial_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .load_data  (bus.a_in),
    .shift      (w_run),
    .serial_in  (1'b0),
    .q          (w_a_q),
    .serial_out (w_a_lsb)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .load_data  (bus.b_in),
    .shift      (w_run),
    .serial_in  (1'b0),
    .q          (w_b_q),
    .serial_out (w_b_lsb)
  );

  // Slice result bits enter at the MSB so that after WIDTH shifts the
  // first (LSB) result bit has arrived at bit 0.
  serial_shift_reg #(.WIDTH(WIDTH)) u_res_sr (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .load_data  ({WIDTH{1'b0}}),
    .shift      (w_run),
    .serial_in  (x),
    .q          (w_res_q),
    .serial_out (w_res_lsb)
  );

  // Only the LSB tap of the operand registers and the parallel view of the
  // result register are consumed here.
  logic unused_taps;
  assign unused_taps = ^{w_a_q, w_b_q, w_res_lsb};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_mode      <= MODE_ADD;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (mode_is_legal(bus.mode)) begin
              r_mode  <= bus.mode;
              r_carry <= 1'b0;
              r_cnt   <= '0;
              r_state <= RUN;
            end else begin
              // Illegal code: report immediately without running the slice.
              r_result    <= '0;
              r_carry_out <= 1'b0;
              r_err       <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        RUN: begin
          r_carry <= c_out;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            // The last slice bit has not been shifted in yet; merge it here.
            r_result    <= {x, w_res_q[WIDTH-1:1]};
            r_carry_out <= (r_mode == MODE_ADD) ? c_out : 1'b0;
            r_err       <= 1'b0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.carry  = r_carry_out;
  assign bus.err    = r_err;
  assign bus.busy   = w_run;
  assign bus.done   = (r_state == DONE);

  assign mode_bit = r_mode;
  assign a_bit    = w_run & w_a_lsb;
  assign b_bit    = w_run & w_b_lsb;
  assign c_bit    = w_run & r_carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_alu_ctrl
// Description : Scoreboard bench for serial_alu_ctrl (WIDTH=8) with a
//               behavioural 1-bit ALU slice attached to the slice ports.
// Ports       : none
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_alu_ctrl;
  import serial_alu_pkg::*;

  localparam int WIDTH = 8;

  logic       clk;
  logic       rst;
  logic [2:0] mode_bit;
  logic       a_bit, b_bit, c_bit;
  logic       x, c_out;

  serial_alu_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mode_bit (mode_bit),
    .a_bit    (a_bit),
    .b_bit    (b_bit),
    .c_bit    (c_bit),
    .x        (x),
    .c_out    (c_out)
  );

  // Behavioural 1-bit ALU slice.
  always_comb begin
    x     = 1'b0;
    c_out = 1'b0;
    case (mode_bit)
      3'b000: begin
        x     = a_bit ^ b_bit ^ c_bit;
        c_out = (a_bit & b_bit) | (a_bit & c_bit) | (b_bit & c_bit);
      end
      3'b001: x = a_bit & b_bit;
      3'b010: x = a_bit | b_bit;
      3'b011: x = a_bit ^ b_bit;
      3'b100: x = ~(a_bit ^ b_bit);
      default: x = 1'b0;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             err;
    int               lat;
    int               busy;
    int               t0;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  int busy_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.busy) begin
        busy_cnt++;
      end else if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("result",  int'(bus.result), int'(e.res));
          check("carry",   int'(bus.carry),  int'(e.carry));
          check("err",     int'(bus.err),    int'(e.err));
          check("latency", cyc - e.t0,       e.lat);
          check("busy_cycles", busy_cnt,     e.busy);
        end
        busy_cnt = 0;
      end else begin
        busy_cnt = 0;
      end
    end
  end

  task automatic push_exp(input logic [WIDTH-1:0] r, input logic c,
                          input logic e, input logic legal);
    exp_t x_e;
    x_e.res   = r;
    x_e.carry = c;
    x_e.err   = e;
    x_e.lat   = legal ? WIDTH + 1 : 1;
    x_e.busy  = legal ? WIDTH : 0;
    x_e.t0    = cyc;
    sb.push_back(x_e);
  endtask

  task automatic wait_done();
    int n = 0;
    #1;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  // Issue one operation, then scramble the inputs to show they are not
  // re-sampled while the operation runs.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input mode_t m, input logic [WIDTH-1:0] r,
                       input logic c, input logic e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.a_in  = a;
    bus.b_in  = b;
    push_exp(r, c, e, mode_is_legal(m));
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = 3'($urandom_range(0, 7));
    bus.a_in  = WIDTH'($urandom);
    bus.b_in  = WIDTH'($urandom);
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"},   int'(bus.result), 0);
    check({tag, "_carry"},    int'(bus.carry),  0);
    check({tag, "_err"},      int'(bus.err),    0);
    check({tag, "_busy"},     int'(bus.busy),   0);
    check({tag, "_done"},     int'(bus.done),   0);
    check({tag, "_mode_bit"}, int'(mode_bit),   0);
    check({tag, "_abc_bits"}, int'({a_bit, b_bit, c_bit}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mode  = MODE_ADD;
    bus.a_in  = '0;
    bus.b_in  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Addition, carry generation and per-operation carry clear.
    do_op(8'h5A, 8'h3C, MODE_ADD, 8'h96, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, MODE_ADD, 8'h00, 1'b1, 1'b0);
    do_op(8'h00, 8'h00, MODE_ADD, 8'h00, 1'b0, 1'b0);

    // Logic operations.
    do_op(8'hF0, 8'h3C, MODE_AND,  8'h30, 1'b0, 1'b0);
    do_op(8'hF0, 8'h3C, MODE_OR,   8'hFC, 1'b0, 1'b0);
    do_op(8'hF0, 8'h3C, MODE_XOR,  8'hCC, 1'b0, 1'b0);
    do_op(8'hF0, 8'h3C, MODE_XNOR, 8'h33, 1'b0, 1'b0);
    check("idle_mode_bit_hold", int'(mode_bit), int'(MODE_XNOR));
    check("idle_abc_bits", int'({a_bit, b_bit, c_bit}), 0);

    // Illegal code, then a legal add clears err.
    do_op(8'hAA, 8'h55, 3'b110, 8'h00, 1'b0, 1'b1);
    do_op(8'h12, 8'h34, MODE_ADD, 8'h46, 1'b0, 1'b0);

    // Start pulses during RUN cycles 3 and 8 are ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = MODE_ADD;
    bus.a_in  = 8'h77;
    bus.b_in  = 8'h11;
    push_exp(8'h88, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= WIDTH; k++) begin
      @(negedge clk);
      bus.start = (k == 3) || (k == 8);
      bus.mode  = 3'b110;
      bus.a_in  = 8'hFF;
      bus.b_in  = 8'hFF;
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Reset during RUN cycle 4 aborts the operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = MODE_XOR;
    bus.a_in  = 8'hA5;
    bus.b_in  = 8'h0F;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_op(8'h01, 8'h02, MODE_ADD, 8'h03, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
